// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, fixed latency.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for Run; outputs hold the last result
// LOAD  | capture operands, clear partial remainder and bit counter
// DIV   | one restoring shift/subtract step per cycle, WIDTH cycles
// DONE  | result valid; stays here until Run is released
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;          // partial remainder
  logic [WIDTH-1:0] qsr_q, qsr_d;      // dividend in, quotient out (shift register)
  logic [WIDTH-1:0] d_q, d_d;          // captured divisor
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  // Shift/subtract datapath for one DIV step. The trial subtraction only
  // succeeds when the shifted remainder is >= D, in which case the true
  // difference is < D and fits in WIDTH bits, so a WIDTH-bit subtract is exact.
  logic [WIDTH:0]   shifted;
  logic             sub_ok;
  logic [WIDTH-1:0] p_step;
  logic [WIDTH-1:0] qsr_step;

  // Trial subtraction of the divisor from {P, next dividend bit}.
  always_comb begin
    shifted  = {p_q, qsr_q[WIDTH-1]};
    sub_ok   = (shifted >= {1'b0, d_q});
    p_step   = sub_ok ? (shifted[WIDTH-1:0] - d_q) : shifted[WIDTH-1:0];
    qsr_step = {qsr_q[WIDTH-2:0], sub_ok};
  end

  // Next-state and datapath update; result registers move only on entry to DONE.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    qsr_d       = qsr_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      IDLE: begin
        if (Run) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        qsr_d = Dividend;
        d_d   = Divisor;
        p_d   = '0;
        cnt_d = '0;
        if (Divisor != '0) begin
          state_d = DIV;
        end else begin
          // Divide by zero short-circuits straight to a flagged result.
          state_d     = DONE;
          quotient_d  = '1;
          remainder_d = Dividend;
          div_zero_d  = 1'b1;
        end
      end

      DIV: begin
        p_d   = p_step;
        qsr_d = qsr_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          quotient_d  = qsr_step;
          remainder_d = p_step;
          div_zero_d  = 1'b0;
        end
      end

      DONE: begin
        // Leaving only on Run low means a held Run cannot retrigger.
        if (!Run) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      p_q         <= '0;
      qsr_q       <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      qsr_q       <= qsr_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  // Status decoded straight from the state register so reset clears it at once.
  always_comb begin
    Busy      = (state_q == LOAD) || (state_q == DIV);
    Done      = (state_q == DONE);
    Quotient  = quotient_q;
    Remainder = remainder_q;
    DivZero   = div_zero_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: stimulus pushes expected results into a
// scoreboard; an independent monitor pops and compares when Done rises.
module tb_seq_divider;

  logic       Clk      = 1'b0;
  logic       Reset    = 1'b0;
  logic       Run      = 1'b0;
  logic [7:0] Dividend = 8'd0;
  logic [7:0] Divisor  = 8'd0;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       Busy;
  logic       Done;
  logic       DivZero;

  seq_divider #(.WIDTH(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Run       (Run),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero)
  );

  always #5 Clk = ~Clk;

  // Count of rising edges; stable when read at a falling edge.
  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    int unsigned dcyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer division; Run is sampled on the next edge,
  // which counts as edge 1 of the 10 (or 2 for divide by zero).
  task automatic push_exp(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 8'd0) begin
      e.q  = 8'hFF;
      e.r  = a;
      e.dz = 1'b1;
      e.dcyc = cyc + 2;
    end else begin
      e.q  = 8'(int'(a) / int'(b));
      e.r  = 8'(int'(a) % int'(b));
      e.dz = 1'b0;
      e.dcyc = cyc + 10;
    end
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      if (!Busy && !Done) idle = 1'b1;
      else @(negedge Clk);
    end
    check("return_to_idle", 32'(idle), 32'd1);
  endtask

  // One operation started from IDLE at a falling edge. Operands stay stable
  // through the capture edge; afterwards they may be scrambled and Run toggled.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input bit rand_run, input bit scramble);
    Dividend = a;
    Divisor  = b;
    Run      = 1'b1;
    push_exp(a, b);
    @(negedge Clk);
    Run = (rand_run && b != 8'd0) ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      if (scramble) begin
        Dividend = 8'($urandom);
        Divisor  = 8'($urandom);
      end
      if (rand_run && b != 8'd0) Run = 1'($urandom_range(0, 1));
      @(negedge Clk);
    end
    Run = 1'b0;
    wait_idle();
  endtask

  // Monitor: result checks on each Done rise, otherwise outputs must hold.
  logic        prev_done = 1'b0;
  logic [16:0] prev_out  = '0;
  always @(negedge Clk) begin
    if (Reset) begin
      if (Done && !prev_done) begin
        if (sb.size() == 0) begin
          check("done_without_request", 32'(Done), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("quotient",  32'(Quotient),  32'(mon_e.q));
          check("remainder", 32'(Remainder), 32'(mon_e.r));
          check("divzero",   32'(DivZero),   32'(mon_e.dz));
          check("latency",   cyc,            mon_e.dcyc);
          check("busy_at_done", 32'(Busy),   32'd0);
        end
      end else begin
        check("hold_outputs", 32'({Quotient, Remainder, DivZero}), 32'(prev_out));
      end
    end
    prev_done = Done;
    prev_out  = {Quotient, Remainder, DivZero};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, b;

    repeat (3) @(negedge Clk);
    #1;
    check("rst_quotient",  32'(Quotient),  32'd0);
    check("rst_remainder", 32'(Remainder), 32'd0);
    check("rst_busy",      32'(Busy),      32'd0);
    check("rst_done",      32'(Done),      32'd0);
    check("rst_divzero",   32'(DivZero),   32'd0);
    @(negedge Clk);
    #2 Reset = 1'b1;
    @(negedge Clk);

    run_op(8'd100, 8'd7,   1'b0, 1'b0);
    run_op(8'd255, 8'd1,   1'b0, 1'b0);
    run_op(8'd255, 8'd255, 1'b0, 1'b0);
    run_op(8'd3,   8'd200, 1'b0, 1'b0);
    run_op(8'd0,   8'd9,   1'b0, 1'b0);
    run_op(8'd5,   8'd0,   1'b0, 1'b0);
    run_op(8'd9,   8'd4,   1'b0, 1'b0);
    run_op(8'd77,  8'd6,   1'b0, 1'b1);

    // Run held high for 30 cycles: one operation, Done held until release.
    Dividend = 8'd123;
    Divisor  = 8'd10;
    Run      = 1'b1;
    push_exp(8'd123, 8'd10);
    repeat (30) @(negedge Clk);
    check("held_done", 32'(Done), 32'd1);
    check("held_busy", 32'(Busy), 32'd0);
    Run = 1'b0;
    @(negedge Clk);
    check("held_release_done", 32'(Done), 32'd0);
    check("held_release_busy", 32'(Busy), 32'd0);

    // Leave a nonzero result visible, then abort 200/13 mid-DIV with reset.
    run_op(8'd5, 8'd0, 1'b0, 1'b0);
    Dividend = 8'd200;
    Divisor  = 8'd13;
    Run      = 1'b1;
    @(negedge Clk);
    Run = 1'b0;
    @(negedge Clk);
    repeat (3) @(negedge Clk);
    check("mid_div_busy", 32'(Busy), 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("abort_quotient",  32'(Quotient),  32'd0);
    check("abort_remainder", 32'(Remainder), 32'd0);
    check("abort_busy",      32'(Busy),      32'd0);
    check("abort_done",      32'(Done),      32'd0);
    check("abort_divzero",   32'(DivZero),   32'd0);
    @(negedge Clk);
    #2 Reset = 1'b1;
    repeat (4) @(negedge Clk);
    check("abort_wait_busy", 32'(Busy), 32'd0);
    check("abort_wait_done", 32'(Done), 32'd0);
    run_op(8'd200, 8'd13, 1'b0, 1'b0);

    // Reset released while Run is already high: starts on the first edge.
    @(negedge Clk);
    #2 Reset = 1'b0;
    Run      = 1'b1;
    Dividend = 8'd42;
    Divisor  = 8'd5;
    @(negedge Clk);
    #2 Reset = 1'b1;
    push_exp(8'd42, 8'd5);
    @(negedge Clk);
    Run = 1'b0;
    repeat (8) @(negedge Clk);
    wait_idle();

    // Randomized operations with Run noise during LOAD/DIV and operand scrambling.
    repeat (40) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_op(a, b, 1'b1, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge Clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; all behaviour below is stated for WIDTH = 8.
REQ-002 SHALL have port Clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Run, input, 1 bit: start request, sampled as a level.
REQ-005 SHALL have port Dividend, input, 8 bits: unsigned dividend.
REQ-006 SHALL have port Divisor, input, 8 bits: unsigned divisor.
REQ-007 SHALL have port Quotient, output, 8 bits: registered quotient.
REQ-008 SHALL have port Remainder, output, 8 bits: registered remainder.
REQ-009 SHALL have port Busy, output, 1 bit: high in LOAD and DIV.
REQ-010 SHALL have port Done, output, 1 bit: high only in DONE.
REQ-011 SHALL have port DivZero, output, 1 bit: result produced with Divisor == 0.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, DIV, DONE, encoded as one registered state variable.
REQ-013 IDLE: Run == 1 at an edge -> LOAD; otherwise stay in IDLE.
REQ-014 LOAD (1 cycle): capture Dividend into quotient-shift register Q, Divisor into D, clear 8-bit partial remainder P and 3-bit counter; -> DIV if D != 0, else -> DONE with the divide-by-zero result (REQ-019).
REQ-015 DIV, once per cycle: S = {P, Q[7]} (9 bits); T = {1'b0, S} - {2'b00, D} (10-bit); T[9] == 0 -> P = T[7:0], Q = {Q[6:0], 1}; else P = S[7:0], Q = {Q[6:0], 0}; counter increments.
REQ-016 DIV SHALL run exactly 8 cycles; on the 8th edge (counter == 7) -> DONE, loading Quotient = Q and Remainder = P after that edge's update.
REQ-017 Latency SHALL be fixed: Done rises on the 10th rising edge after the edge that samples Run high in IDLE (1 LOAD + 8 DIV + entry into DONE).
REQ-018 Quotient, Remainder and DivZero SHALL change only on the edge entering DONE or on reset, and SHALL hold their previous values during LOAD and DIV.
REQ-019 Divide by zero: Quotient = 8'hFF, Remainder = captured dividend, DivZero = 1; Done rises on the 2nd edge after the Run sample.
REQ-020 DivZero SHALL be cleared on entry to DONE for any nonzero divisor.
REQ-021 DONE: stay while Run == 1; -> IDLE on the first edge with Run == 0, so a held Run never triggers a second operation.
REQ-022 Dividend and Divisor changes after the LOAD edge SHALL NOT affect the running result.
REQ-023 Run changes during LOAD or DIV SHALL be ignored.
REQ-024 Arithmetic SHALL be unsigned; results SHALL satisfy Dividend = Quotient*Divisor + Remainder with Remainder < Divisor whenever Divisor != 0.

Reset
REQ-025 Reset low SHALL immediately force IDLE and zero Quotient, Remainder, Busy, Done, DivZero, P, Q, D and the counter, regardless of clock or state.
REQ-026 Reset asserted mid-DIV SHALL abort the operation with no partial result visible; after release, the block SHALL wait in IDLE for a new Run.
REQ-027 After Reset releases with Run already high, the block SHALL start on the first edge, as from IDLE.

Verification
REQ-028 100 / 7, Run pulse -> after 10 edges Done=1, Quotient=14, Remainder=2, DivZero=0, Busy low.
REQ-029 255/1 -> 255 R0; 255/255 -> 1 R0; 3/200 -> 0 R3; 0/9 -> 0 R0, each with exact 10-edge latency.
REQ-030 5 / 0 -> after 2 edges Done=1, Quotient=8'hFF, Remainder=5, DivZero=1; a following 9/4 -> 2 R1 with DivZero=0.
REQ-031 Run held high for 30 cycles -> exactly one operation; Done stays high until Run falls, then IDLE one edge later.
REQ-032 Reset pulsed low at DIV cycle 4 of 200/13 -> all outputs 0 at once; a new 200/13 run -> 15 R5.
REQ-033 Operands changed every cycle during DIV after loading 77/6 -> result 12 R5 unaffected.
